// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
//   Shared constants and helpers for the seven-segment scan driver.
//   Glyphs are active-high, packed as {a,b,c,d,e,f,g}: bit 6 = a, bit 0 = g.
// ---------------------------------------------------------------------------
package seven_seg_pkg;

  // Decimal glyphs
  localparam logic [6:0] GLYPH_0     = 7'b1111110; // abcdef
  localparam logic [6:0] GLYPH_1     = 7'b0110000; // bc
  localparam logic [6:0] GLYPH_2     = 7'b1101101; // abdeg
  localparam logic [6:0] GLYPH_3     = 7'b1111001; // abcdg
  localparam logic [6:0] GLYPH_4     = 7'b0110011; // bcfg
  localparam logic [6:0] GLYPH_5     = 7'b1011011; // acdfg
  localparam logic [6:0] GLYPH_6     = 7'b1011111; // acdefg
  localparam logic [6:0] GLYPH_7     = 7'b1110000; // abc
  localparam logic [6:0] GLYPH_8     = 7'b1111111; // abcdefg
  localparam logic [6:0] GLYPH_9     = 7'b1111011; // abcdfg

  // Hex-only glyphs
  localparam logic [6:0] GLYPH_A     = 7'b1110111; // abcefg
  localparam logic [6:0] GLYPH_B     = 7'b0011111; // cdefg  (lower-case b)
  localparam logic [6:0] GLYPH_C     = 7'b1001110; // adef
  localparam logic [6:0] GLYPH_D     = 7'b0111101; // bcdeg  (lower-case d)
  localparam logic [6:0] GLYPH_E     = 7'b1001111; // adefg
  localparam logic [6:0] GLYPH_F     = 7'b1000111; // aefg

  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // Width of the digit index register. A single-digit display still needs
  // one bit so that the index register has a legal, non-zero width.
  function automatic int idx_width(input int digits);
    int w;
    w = $clog2(digits);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : seven_seg_pkg

// File: rtl/seven_seg_glyph.sv
// ---------------------------------------------------------------------------
// seven_seg_glyph
//   Combinational nibble-to-segment decoder (active-high {a..g}).
//   Ports:
//     nibble_i   [3:0]  code to display
//     hex_mode_i        1 = codes 10-15 render A,b,C,d,E,F; 0 = render blank
//     seg_o      [6:0]  segment pattern, seg_o[6] = a ... seg_o[0] = g
// ---------------------------------------------------------------------------
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      // BCD mode treats 10-15 as invalid codes and shows nothing.
      4'hA: seg_o = hex_mode_i ? GLYPH_A : GLYPH_BLANK;
      4'hB: seg_o = hex_mode_i ? GLYPH_B : GLYPH_BLANK;
      4'hC: seg_o = hex_mode_i ? GLYPH_C : GLYPH_BLANK;
      4'hD: seg_o = hex_mode_i ? GLYPH_D : GLYPH_BLANK;
      4'hE: seg_o = hex_mode_i ? GLYPH_E : GLYPH_BLANK;
      4'hF: seg_o = hex_mode_i ? GLYPH_F : GLYPH_BLANK;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule : seven_seg_glyph

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed DIGITS-digit seven-segment driver. A packed value is
//   captured into a shadow register on load and moved into the display
//   register only at a frame boundary, so a frame is never torn.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     enable              1 = scan; 0 = all digits dark, counters hold
//     load                one-cycle strobe capturing value and dp_in
//     value [4*DIGITS-1:0] packed nibbles, digit 0 in bits [3:0]
//     dp_in [DIGITS-1:0]  decimal point per digit
//     hex_mode            1 = 0-F glyphs; 0 = BCD, 10-15 blank
//     blank_lz            1 = suppress leading zeros (digit 0 never blanked)
//     seg [6:0]           segments {a..g} of the active digit (pin polarity)
//     dp                  decimal point of the active digit (pin polarity)
//     an [DIGITS-1:0]     one-hot digit enable (pin polarity)
//     frame_done          high during the tick that scans the last digit
//
//   Handshake: load is a plain strobe with no backpressure; every cycle it is
//   high the inputs are captured, and the most recent capture before a frame
//   boundary is the one displayed in the next frame.
// ---------------------------------------------------------------------------
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV            = 100000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = idx_width(DIGITS);
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam bit AN_INV  = (AN_ACTIVE_LOW != 0);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PW-1:0]          pre_q,        pre_d;
  logic [IW-1:0]          idx_q,        idx_d;
  logic [4*DIGITS-1:0]    shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]      shadow_dp_q,  shadow_dp_d;
  logic [4*DIGITS-1:0]    disp_val_q,   disp_val_d;
  logic [DIGITS-1:0]      disp_dp_q,    disp_dp_d;
  logic                   pending_q,    pending_d;

  // Registered outputs, active-high internally.
  logic [6:0]             seg_q,        seg_d;
  logic                   dp_q,         dp_d;
  logic [DIGITS-1:0]      an_q,         an_d;

  // -------------------------------------------------------------------------
  // Scan timing
  // -------------------------------------------------------------------------
  logic tick;
  logic frame_end;

  assign tick      = enable && (pre_q == PRE_LAST);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // -------------------------------------------------------------------------
  // Digit selection from the display register
  // -------------------------------------------------------------------------
  logic [3:0]        cur_nibble;
  logic              cur_dp;
  logic              cur_lz;
  logic [DIGITS-1:0] cur_onehot;
  logic [DIGITS-1:0] lz_blank;
  logic              zero_run;
  logic [6:0]        glyph_seg;

  // lz_blank[i] is set when nibbles i..DIGITS-1 are all zero; walking from
  // the top digit down keeps a running "everything above is zero" flag.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_val_q[4*i +: 4] == 4'd0);
      if (i > 0) begin
        lz_blank[i] = zero_run;
      end
    end
  end

  always_comb begin
    cur_nibble = 4'd0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nibble    = disp_val_q[4*i +: 4];
        cur_dp        = disp_dp_q[i];
        cur_lz        = lz_blank[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_glyph u_glyph (
    .nibble_i   (cur_nibble),
    .hex_mode_i (hex_mode),
    .seg_o      (glyph_seg)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Prescaler and digit index only advance while scanning.
    pre_d = pre_q;
    if (enable) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // Shadow capture is unconditional on load, even while disabled.
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end

    // Display only changes at a frame boundary. A load landing on that
    // boundary bypasses the shadow so it is not delayed by a whole frame.
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pending_d  = pending_q;
    if (frame_end) begin
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end

    // Output registers: dark while disabled, refreshed on each tick,
    // otherwise held so the active digit is stable for the whole slot.
    seg_d = seg_q;
    dp_d  = dp_q;
    an_d  = an_q;
    if (!enable) begin
      seg_d = GLYPH_BLANK;
      dp_d  = 1'b0;
      an_d  = '0;
    end else if (tick) begin
      if (blank_lz && cur_lz) begin
        seg_d = GLYPH_BLANK;
        dp_d  = 1'b0;
        an_d  = '0;
      end else begin
        seg_d = glyph_seg;
        dp_d  = cur_dp;
        an_d  = cur_onehot;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      seg_q        <= GLYPH_BLANK;
      dp_q         <= 1'b0;
      an_q         <= '0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  // -------------------------------------------------------------------------
  // Pins: polarity is applied after the register so reset drives every
  // pin to its inactive level regardless of polarity.
  // -------------------------------------------------------------------------
  assign seg        = SEG_INV ? ~seg_q : seg_q;
  assign dp         = SEG_INV ? ~dp_q  : dp_q;
  assign an         = AN_INV  ? ~an_q  : an_q;
  assign frame_done = frame_end;

endmodule : seven_seg_scan_driver
